// File: rtl/start_debouncer.sv
// Purpose : debounce a raw start trigger into a level, edge pulses and a held start request.
// Latency : level/edges/request change SYNC_STAGES+STABLE_TICKS edges after in_btn changes; ack drops req on the sampling edge.
// Backpr. : request held until in_ack; presses seen while a request is outstanding pulse out_missed and are not queued.
//
// Ports:
//    in_clk     - system clock (rising edge)
//    in_rst     - asynchronous active-low reset
//    in_btn     - raw asynchronous, bouncing trigger
//    in_ack     - acknowledge from downstream FSM (only honoured while a request is pending)
//    out_level  - debounced level of in_btn
//    out_rise   - one-cycle pulse on debounced 0->1
//    out_fall   - one-cycle pulse on debounced 1->0
//    out_req    - start request, held until acknowledged
//    out_missed - one-cycle pulse: debounced rise while a request/hold was in progress
//    out_cnt    - count of acknowledged requests, wraps
module start_debouncer #(
   parameter int STABLE_TICKS = 5,
   parameter int SYNC_STAGES  = 2,
   parameter int CNT_BITS     = 8
) (
   input  logic                in_clk,
   input  logic                in_rst,
   input  logic                in_btn,
   input  logic                in_ack,
   output logic                out_level,
   output logic                out_rise,
   output logic                out_fall,
   output logic                out_req,
   output logic                out_missed,
   output logic [CNT_BITS-1:0] out_cnt
);

   localparam int CW = $clog2(STABLE_TICKS) + 1;
   localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CW-1:0]          stab_q, stab_d;
   logic                   level_q, level_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic                   req_q, req_d;
   logic                   missed_q, missed_d;
   logic [CNT_BITS-1:0]    cnt_q, cnt_d;
   logic [1:0]             state_q, state_d;
   logic                   sync_out;

   assign sync_out = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], in_btn};
      stab_d   = stab_q;
      level_d  = level_q;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
      req_d    = req_q;
      missed_d = 1'b0;
      cnt_d    = cnt_q;
      state_d  = state_q;

      // Any return to the current level throws away the partial count,
      // so only an uninterrupted run of STABLE_TICKS cycles flips the level.
      if (sync_out == level_q) begin
         stab_d = '0;
      end else if (stab_q == LAST) begin
         level_d = sync_out;
         stab_d  = '0;
         rise_d  = sync_out;
         fall_d  = ~sync_out;
      end else begin
         stab_d = stab_q + 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            // in_ack is deliberately not looked at here, even if it
            // coincides with the rise event.
            if (rise_d) begin
               state_d = ST_REQ;
               req_d   = 1'b1;
            end
         end
         ST_REQ: begin
            if (in_ack) begin
               req_d   = 1'b0;
               cnt_d   = cnt_q + 1'b1;
               state_d = ST_HOLD;
            end
            if (rise_d) missed_d = 1'b1;
         end
         ST_HOLD: begin
            // Re-arm only after a debounced release, so a button still held
            // after the ack cannot launch a second request.
            if (!level_q) state_d = ST_IDLE;
            if (rise_d) missed_d = 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge in_clk or negedge in_rst) begin
      if (!in_rst) begin
         sync_q   <= '0;
         stab_q   <= '0;
         level_q  <= 1'b0;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
         req_q    <= 1'b0;
         missed_q <= 1'b0;
         cnt_q    <= '0;
         state_q  <= ST_IDLE;
      end else begin
         sync_q   <= sync_d;
         stab_q   <= stab_d;
         level_q  <= level_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         req_q    <= req_d;
         missed_q <= missed_d;
         cnt_q    <= cnt_d;
         state_q  <= state_d;
      end
   end

   assign out_level  = level_q;
   assign out_rise   = rise_q;
   assign out_fall   = fall_q;
   assign out_req    = req_q;
   assign out_missed = missed_q;
   assign out_cnt    = cnt_q;

endmodule

// File: doc/start_debouncer.md
# start_debouncer

Upstream stage of the sequencing state machine: turns a raw, bouncing, asynchronous push-button/trigger line into a clean debounced level, single-cycle edge pulses and a held start request. The request is kept asserted until the downstream FSM acknowledges it, so a start trigger is never lost while the FSM is busy in its wait/step states. Presses arriving while a request is outstanding are reported, not queued.

## Interface
- STABLE_TICKS, default 5: consecutive cycles the synchronised input must differ from the current level before the level flips; legal range ≥ 1.
- SYNC_STAGES, default 2: flip-flop stages in the input synchroniser; legal range ≥ 2.
- CNT_BITS, default 8: width of the accepted-request counter.

Ports:
- in_clk  in  1  system clock; all state changes on its rising edge.
- in_rst  in  1  reset; asynchronous, active-low (0 = reset).
- in_btn  in  1  raw asynchronous trigger input, may bounce.
- in_ack  in  1  acknowledge from the downstream FSM; sampled only while a request is pending.
- out_level  out  1  debounced level of in_btn.
- out_rise  out  1  one-cycle pulse on a debounced 0→1 transition.
- out_fall  out  1  one-cycle pulse on a debounced 1→0 transition.
- out_req  out  1  start request to the FSM, held until acknowledged.
- out_missed  out  1  one-cycle pulse: rising edge occurred while not Idle.
- out_cnt  out  CNT_BITS  number of acknowledged requests, wraps modulo 2^CNT_BITS.

## Operation
- Reset (in_rst = 0, asynchronous): synchroniser, out_level, stability counter, out_rise, out_fall, out_req, out_missed, out_cnt all 0; handshake state Idle.
- Synchroniser: SYNC_STAGES-deep shift register on in_btn; its last stage is sync_out.
- Stability counter, width $clog2(STABLE_TICKS)+1:
  - sync_out == out_level: counter ← 0.
  - sync_out != out_level and counter == STABLE_TICKS−1: out_level ← sync_out, counter ← 0, and out_rise or out_fall ← 1 for that cycle.
  - otherwise counter ← counter+1.
- Any return of sync_out to out_level before the count completes discards the partial count (bounce rejection).
- out_rise / out_fall are registered: high only in the cycle where out_level has just changed, 0 otherwise.
- Handshake FSM:
  - Idle: out_req = 0. On a rising-edge event, go to Req with out_req ← 1 at the same edge at which out_level goes to 1.
  - Req: out_req = 1. in_ack = 1 at an edge: out_req ← 0, out_cnt ← out_cnt+1, go to Hold.
  - Hold: out_req = 0; wait for out_level == 0, then go to Idle.
- in_ack is ignored in Idle and Hold, including when it coincides with the rise event in Idle.
- A rise event in Req or Hold produces out_missed = 1 for one cycle. The state does not change and no second request is queued.
- out_cnt wraps from 2^CNT_BITS−1 to 0 without a flag.

## Timing
- Count the edge that first samples a changed in_btn as edge 1. out_level changes after edge SYNC_STAGES+STABLE_TICKS (defaults: edge 7). out_rise/out_fall and out_req follow on the same edge.
- Glitches on sync_out shorter than STABLE_TICKS cycles have no effect on any output.
- STABLE_TICKS = 1: out_level follows sync_out with one cycle of latency.
- Ack latency: out_req falls on the same edge that samples in_ack = 1. The minimum request width is one cycle, when in_ack is already 1 on the edge after out_req rises.
- Reset mid-operation: all outputs go to 0 immediately, independent of the clock. A pending request is dropped. If in_btn is still high after reset release, a fresh request follows after SYNC_STAGES+STABLE_TICKS edges.

## Test plan
- Clean press, defaults: in_btn 0→1 held. Required: out_level = 1, out_rise pulse and out_req = 1 all after edge 7. Apply in_ack for one cycle: out_req = 0 on that edge, out_cnt = 1.
- Bounce: in_btn toggles 1,0,1,0 every 2 cycles, then stays 1. Required: no output activity during the bounce; out_level rises 7 edges after the final 0→1.
- Missed press: press, no ack, release (out_fall pulse), press again. Required: out_missed = 1 for one cycle at the second rise, out_req stays 1, out_cnt unchanged. Then ack → out_cnt = 1.
- Hold gating: ack while in_btn is still held, then continue holding. Required: no new out_req until a debounced release and a fresh press.
- Wrap and reset: CNT_BITS = 2, four acknowledged presses → out_cnt = 0. Then pull in_rst = 0 mid-request: all outputs 0 without waiting for a clock edge.
